// File: rtl/matrix_chk_pkg.sv
// Shared types and helpers for the matrix stream checker.
//   state_e : checker FSM states (IDLE, RUN, DONE)
//   idx_w() : width of an index able to address n items, never below 1 bit
package matrix_chk_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/matrix_chk_elem_cmp.sv
// Single-element match, purely combinational.
// Optional feature macro: MATRIX_CHK_TOL_EN (adds tol, match when |act-exp_el| <= tol).
// Ports:
//   act     : element from the captured actual matrix
//   exp_el  : expected element from the stream
//   tol     : unsigned absolute tolerance (MATRIX_CHK_TOL_EN only)
//   match_c : 1 when the element is accepted
module matrix_chk_elem_cmp #(
    parameter int unsigned DATA_W = 8
) (
    input  logic [DATA_W-1:0] act,
    input  logic [DATA_W-1:0] exp_el,
`ifdef MATRIX_CHK_TOL_EN
    input  logic [DATA_W-1:0] tol,
`endif
    output logic              match_c
);

`ifdef MATRIX_CHK_TOL_EN
    logic [DATA_W-1:0] diff;

    // Absolute difference without wrap: subtract the smaller from the larger
    always_comb begin
        diff    = (act >= exp_el) ? (act - exp_el) : (exp_el - act);
        match_c = (diff <= tol);
    end
`else
    always_comb begin
        match_c = (act == exp_el);
    end
`endif

endmodule

// File: rtl/matrix_stream_checker.sv
// Compares a streamed expected matrix (row-major, valid/ready) against an
// actual matrix captured on start, counting mismatches and recording the first.
// Optional feature macro: MATRIX_CHK_TOL_EN (adds tol input, tolerance compare).
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   start               : begin a run (accepted only in IDLE)
//   act_mat             : actual matrix, element [r][c] at (r*COLS+c)*DATA_W
//   exp_valid/exp_ready : expected-element handshake, exp_data the element
//   tol                 : match tolerance (MATRIX_CHK_TOL_EN only)
//   busy, done          : in RUN / one-cycle end-of-run pulse
//   pass, err_cnt       : result and mismatch count
//   first_*             : location and values of the first mismatch
module matrix_stream_checker
    import matrix_chk_pkg::*;
#(
    parameter int unsigned ROWS         = 4,
    parameter int unsigned COLS         = 4,
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned STOP_ON_FAIL = 0
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic [ROWS*COLS*DATA_W-1:0]       act_mat,
    input  logic                              exp_valid,
    output logic                              exp_ready,
    input  logic [DATA_W-1:0]                 exp_data,
`ifdef MATRIX_CHK_TOL_EN
    input  logic [DATA_W-1:0]                 tol,
`endif
    output logic                              busy,
    output logic                              done,
    output logic                              pass,
    output logic [$clog2(ROWS*COLS+1)-1:0]    err_cnt,
    output logic                              first_vld,
    output logic [idx_w(ROWS)-1:0]            first_row,
    output logic [idx_w(COLS)-1:0]            first_col,
    output logic [DATA_W-1:0]                 first_act,
    output logic [DATA_W-1:0]                 first_exp
);

    localparam int unsigned N_EL  = ROWS * COLS;
    localparam int unsigned ROW_W = idx_w(ROWS);
    localparam int unsigned COL_W = idx_w(COLS);
    localparam int unsigned EL_W  = idx_w(N_EL);
    localparam int unsigned CNT_W = $clog2(N_EL + 1);

    state_e             state_q, state_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [CNT_W-1:0]   err_cnt_q, err_cnt_d;
    logic               pass_q, pass_d;
    logic               first_vld_q, first_vld_d;
    logic [ROW_W-1:0]   first_row_q, first_row_d;
    logic [COL_W-1:0]   first_col_q, first_col_d;
    logic [DATA_W-1:0]  first_act_q, first_act_d;
    logic [DATA_W-1:0]  first_exp_q, first_exp_d;
    logic [DATA_W-1:0]  snap_q [N_EL];
    logic [DATA_W-1:0]  snap_d [N_EL];

    logic [EL_W-1:0]    el_idx;
    logic [DATA_W-1:0]  act_el;
    logic               match_c;
    logic               last_el;

    // Snapshot element addressed by the current row/column
    always_comb begin
        el_idx = EL_W'(row_q) * EL_W'(COLS) + EL_W'(col_q);
        act_el = snap_q[el_idx];
    end

    matrix_chk_elem_cmp #(
        .DATA_W (DATA_W)
    ) u_cmp (
        .act     (act_el),
        .exp_el  (exp_data),
`ifdef MATRIX_CHK_TOL_EN
        .tol     (tol),
`endif
        .match_c (match_c)
    );

    // Next-state and datapath update
    always_comb begin
        state_d     = state_q;
        row_d       = row_q;
        col_d       = col_q;
        err_cnt_d   = err_cnt_q;
        pass_d      = pass_q;
        first_vld_d = first_vld_q;
        first_row_d = first_row_q;
        first_col_d = first_col_q;
        first_act_d = first_act_q;
        first_exp_d = first_exp_q;
        snap_d      = snap_q;
        last_el     = (row_q == ROW_W'(ROWS - 1)) && (col_q == COL_W'(COLS - 1));

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_RUN;
                    row_d       = '0;
                    col_d       = '0;
                    err_cnt_d   = '0;
                    pass_d      = 1'b0;
                    first_vld_d = 1'b0;
                    first_row_d = '0;
                    first_col_d = '0;
                    first_act_d = '0;
                    first_exp_d = '0;
                    for (int unsigned i = 0; i < N_EL; i++) begin
                        snap_d[i] = act_mat[i*DATA_W +: DATA_W];
                    end
                end
            end
            ST_RUN: begin
                if (exp_valid) begin
                    if (!match_c) begin
                        err_cnt_d = err_cnt_q + CNT_W'(1);
                        if (!first_vld_q) begin
                            first_vld_d = 1'b1;
                            first_row_d = row_q;
                            first_col_d = col_q;
                            first_act_d = act_el;
                            first_exp_d = exp_data;
                        end
                    end
                    if (col_q == COL_W'(COLS - 1)) begin
                        col_d = '0;
                        row_d = row_q + ROW_W'(1);
                    end else begin
                        col_d = col_q + COL_W'(1);
                    end
                    if (last_el || ((STOP_ON_FAIL != 0) && !match_c)) begin
                        state_d = ST_DONE;
                        pass_d  = (err_cnt_d == '0);
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            row_q       <= '0;
            col_q       <= '0;
            err_cnt_q   <= '0;
            pass_q      <= 1'b0;
            first_vld_q <= 1'b0;
            first_row_q <= '0;
            first_col_q <= '0;
            first_act_q <= '0;
            first_exp_q <= '0;
            for (int unsigned i = 0; i < N_EL; i++) begin
                snap_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            row_q       <= row_d;
            col_q       <= col_d;
            err_cnt_q   <= err_cnt_d;
            pass_q      <= pass_d;
            first_vld_q <= first_vld_d;
            first_row_q <= first_row_d;
            first_col_q <= first_col_d;
            first_act_q <= first_act_d;
            first_exp_q <= first_exp_d;
            snap_q      <= snap_d;
        end
    end

    // Status outputs decode straight from the state register
    assign busy      = (state_q == ST_RUN);
    assign exp_ready = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign err_cnt   = err_cnt_q;
    assign first_vld = first_vld_q;
    assign first_row = first_row_q;
    assign first_col = first_col_q;
    assign first_act = first_act_q;
    assign first_exp = first_exp_q;

endmodule

// File: tb/tb_matrix_stream_checker.sv
// Directed bench for matrix_stream_checker: instance 0 runs with
// STOP_ON_FAIL=0, instance 1 with STOP_ON_FAIL=1. Both share the matrix and
// stream inputs; only the instance being started consumes the stream.
// Tolerance scenario is included when MATRIX_CHK_TOL_EN is defined.
module tb_matrix_stream_checker;

    localparam int unsigned ROWS   = 4;
    localparam int unsigned COLS   = 4;
    localparam int unsigned DATA_W = 8;
    localparam int unsigned N_EL   = ROWS * COLS;

    logic                         clk = 1'b0;
    logic                         rst;
    logic                         start0, start1;
    logic [N_EL*DATA_W-1:0]       act_mat;
    logic                         exp_valid;
    logic [DATA_W-1:0]            exp_data;
`ifdef MATRIX_CHK_TOL_EN
    logic [DATA_W-1:0]            tol;
`endif

    logic       exp_ready0, busy0, done0, pass0, first_vld0;
    logic [4:0] err_cnt0;
    logic [1:0] first_row0, first_col0;
    logic [7:0] first_act0, first_exp0;

    logic       exp_ready1, busy1, done1, pass1, first_vld1;
    logic [4:0] err_cnt1;
    logic [1:0] first_row1, first_col1;
    logic [7:0] first_act1, first_exp1;

    int n_checks = 0;
    int n_fail   = 0;
    logic [7:0] exp_vec [N_EL];

    always #5 clk = ~clk;

    matrix_stream_checker #(
        .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .STOP_ON_FAIL(0)
    ) u_dut0 (
        .clk(clk), .rst(rst), .start(start0), .act_mat(act_mat),
        .exp_valid(exp_valid), .exp_ready(exp_ready0), .exp_data(exp_data),
`ifdef MATRIX_CHK_TOL_EN
        .tol(tol),
`endif
        .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err_cnt0),
        .first_vld(first_vld0), .first_row(first_row0), .first_col(first_col0),
        .first_act(first_act0), .first_exp(first_exp0)
    );

    matrix_stream_checker #(
        .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .STOP_ON_FAIL(1)
    ) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .act_mat(act_mat),
        .exp_valid(exp_valid), .exp_ready(exp_ready1), .exp_data(exp_data),
`ifdef MATRIX_CHK_TOL_EN
        .tol(tol),
`endif
        .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err_cnt1),
        .first_vld(first_vld1), .first_row(first_row1), .first_col(first_col1),
        .first_act(first_act1), .first_exp(first_exp1)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic fill_ident();
        for (int i = 0; i < int'(N_EL); i++) exp_vec[i] = 8'(i);
    endtask

    // Starts one instance and streams exp_vec; start is held high through the
    // run so a restart-while-busy would corrupt the result. Returns at the
    // cycle done is seen, or right after max_x transfers.
    task automatic run_stream(input bit inst, input int gap_pct, input int max_x,
                              input bit scramble, output int cycles, output int xfers);
        bit dn, rdy;
        xfers  = 0;
        cycles = 0;
        @(negedge clk);
        if (inst) start1 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        cycles = 1;
        if (scramble) act_mat = ~act_mat;
        while (cycles < 300) begin
            dn  = inst ? done1 : done0;
            rdy = inst ? exp_ready1 : exp_ready0;
            if (dn || xfers == max_x) break;
            if (rdy && xfers < int'(N_EL) && $urandom_range(99) >= gap_pct) begin
                exp_valid = 1'b1;
                exp_data  = exp_vec[xfers];
                xfers++;
            end else begin
                exp_valid = 1'b0;
                exp_data  = 8'($urandom());
            end
            @(negedge clk);
            cycles++;
        end
        exp_valid = 1'b0;
        start0    = 1'b0;
        start1    = 1'b0;
        check_eq("run_bounded", 32'(cycles < 300), 32'd1);
    endtask

    initial begin
        int cyc, nx;
        rst       = 1'b1;
        start0    = 1'b0;
        start1    = 1'b0;
        exp_valid = 1'b0;
        exp_data  = '0;
`ifdef MATRIX_CHK_TOL_EN
        tol       = '0;
`endif
        for (int i = 0; i < int'(N_EL); i++) act_mat[i*DATA_W +: DATA_W] = 8'(i);
        repeat (3) @(negedge clk);

        check_eq("rst_busy",      busy0,      0);
        check_eq("rst_ready",     exp_ready0, 0);
        check_eq("rst_done",      done0,      0);
        check_eq("rst_pass",      pass0,      0);
        check_eq("rst_err_cnt",   err_cnt0,   0);
        check_eq("rst_first_vld", first_vld0, 0);
        rst = 1'b0;

        // Clean back-to-back run
        fill_ident();
        run_stream(1'b0, 0, 16, 1'b0, cyc, nx);
        check_eq("a_done_cycle", cyc,        17);
        check_eq("a_done",       done0,      1);
        check_eq("a_pass",       pass0,      1);
        check_eq("a_err_cnt",    err_cnt0,   0);
        check_eq("a_first_vld",  first_vld0, 0);
        check_eq("a_busy_done",  busy0,      0);
        start0 = 1'b1;                          // start during DONE is ignored
        @(negedge clk);
        start0 = 1'b0;
        check_eq("a_done_pulse", done0, 0);
        check_eq("a_start_in_done_ignored", busy0, 0);
        check_eq("a_pass_hold",  pass0, 1);
        @(negedge clk);
        check_eq("a_idle_stays", busy0, 0);

        // Two mismatches, no early stop
        fill_ident();
        exp_vec[9]  = 8'hAA;
        exp_vec[15] = 8'h00;
        run_stream(1'b0, 0, 16, 1'b0, cyc, nx);
        check_eq("b_done_cycle", cyc,        17);
        check_eq("b_err_cnt",    err_cnt0,   2);
        check_eq("b_first_vld",  first_vld0, 1);
        check_eq("b_first_row",  first_row0, 2);
        check_eq("b_first_col",  first_col0, 1);
        check_eq("b_first_act",  first_act0, 8'h09);
        check_eq("b_first_exp",  first_exp0, 8'hAA);
        check_eq("b_pass",       pass0,      0);

        // Stop on first failure
        fill_ident();
        exp_vec[2] = 8'hFF;
        run_stream(1'b1, 0, 16, 1'b0, cyc, nx);
        check_eq("c_xfers",      nx,         3);
        check_eq("c_done",       done1,      1);
        check_eq("c_err_cnt",    err_cnt1,   1);
        check_eq("c_first_row",  first_row1, 0);
        check_eq("c_first_col",  first_col1, 2);
        check_eq("c_first_act",  first_act1, 8'h02);
        check_eq("c_first_exp",  first_exp1, 8'hFF);
        check_eq("c_pass",       pass1,      0);
        check_eq("c_ready_done", exp_ready1, 0);
        @(negedge clk);
        check_eq("c_ready_after", exp_ready1, 0);
        check_eq("c_busy_after",  busy1,      0);

        // Random gaps and act_mat changed after start
        fill_ident();
        run_stream(1'b0, 30, 16, 1'b1, cyc, nx);
        act_mat = ~act_mat;
        check_eq("d_xfers",     nx,         16);
        check_eq("d_done",      done0,      1);
        check_eq("d_pass",      pass0,      1);
        check_eq("d_err_cnt",   err_cnt0,   0);
        check_eq("d_first_vld", first_vld0, 0);

        // Reset mid-run after 7 transfers (one mismatch), reset beats start
        fill_ident();
        exp_vec[1] = 8'h55;
        run_stream(1'b0, 0, 7, 1'b0, cyc, nx);
        check_eq("e_xfers",         nx,         7);
        check_eq("e_busy_mid",      busy0,      1);
        check_eq("e_err_mid",       err_cnt0,   1);
        check_eq("e_first_act_mid", first_act0, 8'h01);
        rst    = 1'b1;
        start0 = 1'b1;
        @(negedge clk);
        rst    = 1'b0;
        start0 = 1'b0;
        check_eq("e_rst_busy",      busy0,      0);
        check_eq("e_rst_ready",     exp_ready0, 0);
        check_eq("e_rst_done",      done0,      0);
        check_eq("e_rst_pass",      pass0,      0);
        check_eq("e_rst_err_cnt",   err_cnt0,   0);
        check_eq("e_rst_first_vld", first_vld0, 0);
        check_eq("e_rst_first_col", first_col0, 0);
        check_eq("e_rst_first_act", first_act0, 0);
        check_eq("e_rst_first_exp", first_exp0, 0);
        fill_ident();
        run_stream(1'b0, 0, 16, 1'b0, cyc, nx);
        check_eq("e_rerun_cycle", cyc,      17);
        check_eq("e_rerun_pass",  pass0,    1);
        check_eq("e_rerun_err",   err_cnt0, 0);

`ifdef MATRIX_CHK_TOL_EN
        // Tolerance 2: offset of +2 accepted, +3 at [1][1] rejected
        tol = 8'h02;
        for (int i = 0; i < int'(N_EL); i++) exp_vec[i] = 8'(i + 2);
        exp_vec[5] = 8'h08;
        run_stream(1'b0, 0, 16, 1'b0, cyc, nx);
        check_eq("f_err_cnt",   err_cnt0,   1);
        check_eq("f_first_row", first_row0, 1);
        check_eq("f_first_col", first_col0, 1);
        check_eq("f_first_act", first_act0, 8'h05);
        check_eq("f_first_exp", first_exp0, 8'h08);
        check_eq("f_pass",      pass0,      0);
        tol = 8'h00;
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/matrix_stream_checker.md
MATRIX_STREAM_CHECKER -- requirements
Module: matrix_stream_checker

Interface
REQ-001 ROWS, default 4, number of matrix rows (>=1) SHALL be a parameter.
REQ-002 COLS, default 4, number of matrix columns (>=1) SHALL be a parameter.
REQ-003 DATA_W, default 8, element width in bits SHALL be a parameter.
REQ-004 STOP_ON_FAIL, default 0, 1 = terminate the run at the first mismatch, SHALL be a parameter.
REQ-005 clk  input  1  the single clock; all state SHALL update on its rising edge.
REQ-006 rst  input  1  reset, SHALL be synchronous and active-high.
REQ-007 start  input  1  SHALL begin a run when sampled high in IDLE.
REQ-008 act_mat  input  ROWS*COLS*DATA_W  actual matrix, row-major, element [r][c] at bit offset (r*COLS+c)*DATA_W, SHALL be sampled on start.
REQ-009 exp_valid / exp_ready  input / output  1 / 1  expected-element handshake; transfer SHALL occur when both are high.
REQ-010 exp_data  input  DATA_W  expected element, row-major order.
REQ-011 busy  output  1  high in RUN.
REQ-012 done  output  1  single-cycle end-of-run pulse.
REQ-013 pass  output  1  result of last completed run.
REQ-014 err_cnt  output  $clog2(ROWS*COLS+1)  mismatch count of current/last run.
REQ-015 first_vld, first_row, first_col, first_act, first_exp  outputs  1, $clog2(ROWS) (min 1), $clog2(COLS) (min 1), DATA_W, DATA_W  first-mismatch capture.

Function
REQ-016 FSM states IDLE, RUN, DONE; IDLE->RUN on start; RUN->DONE on last-element transfer or (STOP_ON_FAIL=1 and mismatching transfer); DONE->IDLE unconditionally after one cycle.
REQ-017 On start, act_mat SHALL be copied to an internal snapshot; later act_mat changes SHALL not affect the run.
REQ-018 On start, err_cnt, first_vld, pass, row/col counters SHALL clear to 0.
REQ-019 exp_ready SHALL equal (state==RUN); exp_data SHALL be ignored when exp_ready is low.
REQ-020 Each transfer SHALL compare exp_data against snapshot[row][col]; col SHALL increment, wrap COLS-1->0 with row incrementing; element ROWS-1,COLS-1 is last.
REQ-021 A mismatch SHALL increment err_cnt (no saturation needed, max ROWS*COLS); the first mismatch SHALL load first_row/col/act/exp and set first_vld, held until next start.
REQ-022 done SHALL be high exactly in the DONE cycle, i.e. one cycle after the terminating transfer; pass SHALL update in that same cycle to (err_cnt==0) and hold.
REQ-023 start while busy or in DONE SHALL be ignored.
REQ-024 Gaps (exp_valid low) in RUN SHALL stall counters without affecting results.

Reset
REQ-025 rst SHALL force IDLE and zero busy, done, pass, err_cnt, first_* outputs, counters and snapshot, including mid-run; rst SHALL take priority over start.

Configuration
REQ-026 With MATRIX_CHK_TOL_EN defined, input tol (DATA_W, unsigned) SHALL exist and an element SHALL match when |act-exp| <= tol (unsigned, no wrap); without it, tol SHALL be absent and match SHALL be exact equality.

Structure
REQ-027 Package matrix_chk_pkg SHALL hold the state enum and an index-width helper function.
REQ-028 Sub-module matrix_chk_elem_cmp SHALL implement the single-element match (exact or tolerance), purely combinational.

Verification
REQ-029 4x4x8, act_mat 00..0F row-major, exp stream 00..0F back-to-back -> done at cycle 17 after start, pass=1, err_cnt=0, first_vld=0.
REQ-030 Same, exp[2][1]=AA and exp[3][3]=00, STOP_ON_FAIL=0 -> err_cnt=2, first_row=2, first_col=1, first_act=09, first_exp=AA, pass=0.
REQ-031 STOP_ON_FAIL=1, exp[0][2]=FF -> done after 3rd transfer, err_cnt=1, exp_ready low thereafter.
REQ-032 Random exp_valid gaps plus act_mat changed after start -> results identical to REQ-029.
REQ-033 rst pulsed after 7 transfers -> all outputs 0, IDLE; new run then passes normally.
REQ-034 MATRIX_CHK_TOL_EN, tol=02, exp = act+2 everywhere except [1][1]=act+3 -> err_cnt=1, first_row=1, first_col=1.
